// File: rtl/reg_access_pkg.sv
// Shared definitions for the register-extern request controller.
//   op_e      : request operation encodings
//   state_e   : controller FSM states
//   RAM_RD_LAT: BRAM read latency (enable to registered output)
package reg_access_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_ADD   = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        LATCH,
        CAPTURE,
        WRITE,
        RESP
    } state_e;

    localparam int RAM_RD_LAT = 2;

endpackage

// File: rtl/reg_access_alu.sv
// Combinational adder for fetch-and-add.
//   a   : current register value (BRAM output)
//   b   : addend
//   sum : value to store back
// Build option REG_ACCESS_SATURATE_EN: unsigned overflow clamps to all-ones.
// Without it the sum wraps modulo 2**WIDTH.
module reg_access_alu import reg_access_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

`ifdef REG_ACCESS_SATURATE_EN
    logic [WIDTH:0] full;

    assign full = {1'b0, a} + {1'b0, b};
    assign sum  = full[WIDTH] ? {WIDTH{1'b1}} : full[WIDTH-1:0];
`else
    assign sum = a + b;
`endif

endmodule

// File: rtl/reg_access_ctrl.sv
// Request-side controller for the register-extern single-port BRAM
// (2-cycle read latency, registered output). One request at a time;
// read, write and fetch-and-add; one response per request.
//   clk, rst                  : clock, synchronous active-high reset
//   req_valid/ready/op/addr/data : request handshake
//   resp_valid/ready/data/err : response handshake
//   ram_en/we/regce/rst/addr/din : BRAM controls, ram_dout : BRAM output
// Build option REG_ACCESS_SATURATE_EN selects saturating fetch-and-add.
//
//   state   | meaning
//   IDLE    | ready for a request; after a handshake, waits out the issue delay
//   ISSUE   | BRAM enable with read address
//   LATCH   | BRAM output-register enable
//   CAPTURE | ram_dout valid: capture read value, compute sum for add
//   WRITE   | BRAM write of request data or sum
//   RESP    | response presented until resp_ready
module reg_access_ctrl import reg_access_pkg::*; #(
    parameter int L2_DEPTH = 8,
    parameter int WIDTH    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [L2_DEPTH-1:0] req_addr,
    input  logic [WIDTH-1:0]    req_data,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [WIDTH-1:0]    resp_data,
    output logic                resp_err,
    output logic                ram_en,
    output logic                ram_we,
    output logic                ram_regce,
    output logic                ram_rst,
    output logic [L2_DEPTH-1:0] ram_addr,
    output logic [WIDTH-1:0]    ram_din,
    input  logic [WIDTH-1:0]    ram_dout
);

    state_e              state;
    op_e                 op_q;
    logic [L2_DEPTH-1:0] addr_q;
    logic [WIDTH-1:0]    data_q;
    logic [1:0]          dly;
    logic                rdy_q;
    logic                en_q;
    logic                we_q;
    logic                regce_q;
    logic [WIDTH-1:0]    sum;

    reg_access_alu #(.WIDTH(WIDTH)) u_alu (
        .a   (ram_dout),
        .b   (data_q),
        .sum (sum)
    );

    // Reset gates the strobes immediately so a WRITE cycle hit by reset
    // never reaches the array.
    assign req_ready = rdy_q & ~rst;
    assign ram_en    = en_q & ~rst;
    assign ram_we    = we_q & ~rst;
    assign ram_regce = regce_q & ~rst;
    assign ram_rst   = rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= OP_READ;
            addr_q     <= '0;
            data_q     <= '0;
            dly        <= '0;
            rdy_q      <= 1'b1;
            en_q       <= 1'b0;
            we_q       <= 1'b0;
            regce_q    <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rdy_q) begin
                        if (req_valid) begin
                            op_q   <= op_e'(req_op);
                            addr_q <= req_addr;
                            data_q <= req_data;
                            rdy_q  <= 1'b0;
                            // The error path takes one extra cycle so a reserved
                            // op answers with the same latency as a write.
                            dly    <= (op_e'(req_op) == OP_RSVD) ? 2'd2 : 2'd1;
                        end
                    end else if (dly == 2'd1) begin
                        case (op_q)
                            OP_READ, OP_ADD: begin
                                state    <= ISSUE;
                                en_q     <= 1'b1;
                                ram_addr <= addr_q;
                            end
                            OP_WRITE: begin
                                state     <= WRITE;
                                en_q      <= 1'b1;
                                we_q      <= 1'b1;
                                ram_addr  <= addr_q;
                                ram_din   <= data_q;
                                resp_data <= data_q;
                            end
                            default: begin
                                state      <= RESP;
                                resp_valid <= 1'b1;
                                resp_err   <= 1'b1;
                                resp_data  <= '0;
                            end
                        endcase
                    end else begin
                        dly <= dly - 2'd1;
                    end
                end
                ISSUE: begin
                    en_q    <= 1'b0;
                    regce_q <= 1'b1;
                    state   <= LATCH;
                end
                LATCH: begin
                    regce_q <= 1'b0;
                    state   <= CAPTURE;
                end
                CAPTURE: begin
                    resp_data <= ram_dout;
                    if (op_q == OP_ADD) begin
                        state   <= WRITE;
                        en_q    <= 1'b1;
                        we_q    <= 1'b1;
                        ram_din <= sum;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end
                end
                WRITE: begin
                    en_q       <= 1'b0;
                    we_q       <= 1'b0;
                    state      <= RESP;
                    resp_valid <= 1'b1;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        rdy_q      <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    rdy_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl with a behavioural 2-cycle BRAM,
// a shadow register model and a response scoreboard.
module tb_reg_access_ctrl;
    import reg_access_pkg::*;

    localparam int L2 = 8;
    localparam int W  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [L2-1:0] req_addr;
    logic [W-1:0]  req_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [W-1:0]  resp_data;
    logic          resp_err;
    logic          ram_en, ram_we, ram_regce, ram_rst;
    logic [L2-1:0] ram_addr;
    logic [W-1:0]  ram_din;
    logic [W-1:0]  ram_dout;

    always #5 clk = ~clk;

    reg_access_ctrl #(.L2_DEPTH(L2), .WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_regce(ram_regce), .ram_rst(ram_rst),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Behavioural BRAM: array read on enable, output register on regce.
    logic [W-1:0] mem [0:(1<<L2)-1];
    logic [W-1:0] stage;
    int           en_cnt = 0;
    int           wr_cnt = 0;

    always @(posedge clk) begin
        if (ram_en) begin
            en_cnt <= en_cnt + 1;
            if (ram_we) begin
                mem[ram_addr] <= ram_din;
                wr_cnt        <= wr_cnt + 1;
            end else begin
                stage <= mem[ram_addr];
            end
        end
        if (ram_rst)        ram_dout <= '0;
        else if (ram_regce) ram_dout <= stage;
    end

    typedef struct packed {
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] shadow [0:(1<<L2)-1];
    int           n_vec = 0;
    int           n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_outs"},
            {resp_valid, resp_err, ram_en, ram_we, ram_regce, ram_rst,
             resp_data, ram_addr, ram_din}, '0);
        chk({tag, "_ready"}, req_ready, 1);
    endtask

    task automatic do_req(input logic [1:0] op, input logic [L2-1:0] addr,
                          input logic [W-1:0] data, input int lat,
                          input int stall, input string tag);
        exp_t         e;
        logic [W:0]   s;
        logic [W-1:0] nv;
        int           cyc;
        case (op)
            OP_READ:  e = '{data: shadow[addr], err: 1'b0};
            OP_WRITE: begin
                e = '{data: data, err: 1'b0};
                shadow[addr] = data;
            end
            OP_ADD: begin
                e = '{data: shadow[addr], err: 1'b0};
                s = {1'b0, shadow[addr]} + {1'b0, data};
`ifdef REG_ACCESS_SATURATE_EN
                nv = s[W] ? {W{1'b1}} : s[W-1:0];
`else
                nv = s[W-1:0];
`endif
                shadow[addr] = nv;
            end
            default:  e = '{data: '0, err: 1'b1};
        endcase
        sb.push_back(e);

        @(negedge clk);
        req_valid  = 1'b1;
        req_op     = op;
        req_addr   = addr;
        req_data   = data;
        resp_ready = (stall == 0);
        cyc = 0;
        while (req_ready !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_accept"}, req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cyc = 0;
        while (resp_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_lat"}, cyc, lat);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            for (int i = 0; i < stall; i++) begin
                chk({tag, "_stall"}, {resp_valid, req_ready, resp_data},
                    {1'b1, 1'b0, e.data});
                @(posedge clk);
                #1;
            end
            resp_ready = 1'b1;
            chk({tag, "_data"}, resp_data, e.data);
            chk({tag, "_err"}, resp_err, e.err);
        end
        @(posedge clk);
        #1;
        chk({tag, "_done"}, {resp_valid, req_ready}, 2'b01);
    endtask

    int en_before;
    int wr_before;

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = '0;
        req_addr   = '0;
        req_data   = '0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_outs("post_rst");

        do_req(OP_WRITE, 8'h05, 32'hDEADBEEF, 2, 0, "wr05");
        do_req(OP_READ,  8'h05, 32'h0,        4, 0, "rd05");

        do_req(OP_WRITE, 8'h10, 32'h7, 2, 0, "wr10");
        do_req(OP_ADD,   8'h10, 32'h3, 5, 0, "add10");
        do_req(OP_READ,  8'h10, 32'h0, 4, 0, "rd10");

        do_req(OP_WRITE, 8'h20, 32'hFFFFFFFF, 2, 0, "wr20");
        do_req(OP_ADD,   8'h20, 32'h2,        5, 0, "add20");
        do_req(OP_READ,  8'h20, 32'h0,        4, 0, "rd20");

        do_req(OP_WRITE, 8'hFF, 32'h12345678, 2, 0, "wrff");
        do_req(OP_READ,  8'hFF, 32'h0,        4, 0, "rdff");

        en_before = en_cnt;
        do_req(OP_RSVD, 8'h05, 32'hA5A5A5A5, 2, 0, "rsvd");
        chk("rsvd_no_en", en_cnt - en_before, 0);

        do_req(OP_READ, 8'h05, 32'h0, 4, 10, "rd_stall");

        // Reset lands on the WRITE cycle of an add; the store must not happen.
        do_req(OP_WRITE, 8'h30, 32'h1, 2, 0, "wr30");
        wr_before = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_ADD;
        req_addr  = 8'h30;
        req_data  = 32'h5;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_add_we_pre", {ram_en, ram_we}, 2'b11);
        rst = 1'b1;
        #1;
        chk("rst_add_we_gate", ram_we, 0);
        @(posedge clk);
        #1;
        chk("rst_add_no_write", wr_cnt - wr_before, 0);
        chk("rst_add_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_outs("mid_rst");
        do_req(OP_READ, 8'h30, 32'h0, 4, 0, "rd30");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_access_ctrl.md
# reg_access_ctrl

Request-side controller for the register-extern single-port BRAM (2-cycle read latency, registered output). Accepts one register request at a time from the P4 extern pipeline over a valid/ready handshake and sequences the BRAM enable, write, and output-register controls. Supports read, write and fetch-and-add. Returns one response per request over a second valid/ready handshake.

## Interface
- L2_DEPTH, 8, address width; BRAM depth is 2**L2_DEPTH
- WIDTH, 32, data width
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  2  operation: 00 read, 01 write, 10 fetch-and-add, 11 reserved
- req_addr  in  L2_DEPTH  register index
- req_data  in  WIDTH  write data or addend
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts the response
- resp_data  out  WIDTH  read value, written value, or pre-add value
- resp_err  out  1  reserved op was received
- ram_en, ram_we, ram_regce, ram_rst  out  1 each  BRAM controls
- ram_addr  out  L2_DEPTH  BRAM address
- ram_din  out  WIDTH  BRAM write data
- ram_dout  in  WIDTH  BRAM registered output

## Operation
- FSM states: IDLE, ISSUE, LATCH, CAPTURE, WRITE, RESP.
- IDLE is the only state that asserts req_ready. A handshake (req_valid & req_ready) registers op, addr and data.
- Next state after a handshake in IDLE:
  - read → ISSUE
  - add → ISSUE
  - write → WRITE
  - reserved → RESP with resp_err=1 and resp_data=0. No RAM access.
- ISSUE: ram_en=1, ram_we=0, ram_addr=captured addr. Next state LATCH.
- LATCH: ram_regce=1. Next state CAPTURE.
- CAPTURE: ram_dout is valid.
  - resp_data ← ram_dout.
  - For add, sum ← ram_dout + data, truncated to WIDTH (wraps mod 2**WIDTH). Next state WRITE.
  - For read, next state RESP.
- WRITE: ram_en=1, ram_we=1, ram_addr=captured addr.
  - ram_din = data for a write, sum for an add.
  - For a write, resp_data ← data.
  - Next state RESP.
- RESP: resp_valid=1. resp_data and resp_err are held stable until resp_ready. On resp_ready the FSM returns to IDLE.
- ram_en, ram_we and ram_regce are 0 in every state except where listed above. ram_rst = rst.
- Reset at any point, including mid-operation: FSM → IDLE and the in-flight request is dropped.
  - A WRITE cycle coinciding with rst is suppressed: ram_we=0 while rst=1.

## Timing
- Reset values: req_ready=0 while rst=1 and 1 in the first cycle after reset. resp_valid=0, resp_data=0, resp_err=0, all ram_* controls=0, ram_addr=0, ram_din=0.
- Handshake at edge T. The first cycle with resp_valid=1 is:
  - read: T+4
  - write: T+2 (RAM written at edge T+2)
  - add: T+5 (RAM written at edge T+5)
  - reserved: T+2
- If resp_ready is already high, the next req_ready is one cycle after the response handshake.
- resp_ready may be held high permanently. resp_ready=0 stalls in RESP indefinitely.
- A request arriving while not in IDLE waits; its inputs must be held until req_ready.

## Configuration
- REG_ACCESS_SATURATE_EN defined: fetch-and-add saturates. When the unsigned sum overflows WIDTH, the stored value is all-ones.
- Not defined: the sum wraps mod 2**WIDTH.
- resp_data is always the pre-add value in both cases.

## Structure
- Shared package reg_access_pkg holds:
  - op encodings: OP_READ, OP_WRITE, OP_ADD, OP_RSVD
  - FSM state enum
  - read-latency constant RAM_RD_LAT=2
- One natural sub-module, reg_access_alu: combinational add with a saturation option, parameterized on WIDTH.

## Test plan
- After reset, write addr 0x05 with 0xDEADBEEF, then read addr 0x05 → write response (resp_data=0xDEADBEEF) at T+2; read response resp_data=0xDEADBEEF at T+4.
- Add 0x3 to addr 0x10 holding 0x7 → resp_data=0x7 at T+5; a following read returns 0xA.
- Add 0x2 to addr 0x20 holding 0xFFFFFFFF → without the macro the stored value is 0x1; with REG_ACCESS_SATURATE_EN it is 0xFFFFFFFF. resp_data=0xFFFFFFFF in both cases.
- Reserved op 11 → resp_err=1, resp_data=0 at T+2; no ram_en pulse.
- Hold resp_ready=0 for 10 cycles during a read response → resp_valid and resp_data stay stable and req_ready stays 0. The response handshake occurs on the first cycle resp_ready=1.
- Assert rst during WRITE of an add to addr 0x30 holding 0x1 → no RAM write; a read after reset returns 0x1; all outputs are at reset values.
